// File: rtl/serial_borrow_sub.sv
// serial_borrow_sub: bit-serial ripple-borrow subtractor D = A - B - Bin, LSB first, one bit per clock.
// Optional signed-overflow output V is built when SUB_OVERFLOW_EN is defined.
module serial_borrow_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SUB_OVERFLOW_EN
   ,output logic             V
`endif
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-2:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_q;
    logic             br_q, d_d, br_d;
    // full-subtractor cell on the current LSBs, plus the result register with this bit shifted in
    always_comb begin
        d_d   = a_q[0] ^ b_q[0] ^ br_q;
        br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_d = {d_d, res_q};
    end
    // control FSM and datapath registers; outputs are registered and held until the next completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            D       <= '0;
            Bout    <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            V       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        br_q    <= Bin;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    res_q <= res_d[WIDTH-1:1];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        D       <= res_d;
                        Bout    <= br_d;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= DONE;
`ifdef SUB_OVERFLOW_EN
                        // operand MSBs have been shifted down to bit 0 by the last bit-cycle
                        V       <= (a_q[0] ^ b_q[0]) & (a_q[0] ^ d_d);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_borrow_sub.sv
// tb_serial_borrow_sub: directed-vector bench for serial_borrow_sub (WIDTH=4); covers V when SUB_OVERFLOW_EN is defined.
module tb_serial_borrow_sub;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] A = '0, B = '0;
    logic       Bin = 1'b0;
    logic       busy, done, Bout;
    logic [3:0] D;
`ifdef SUB_OVERFLOW_EN
    logic       V;
`endif
    int total = 0, bad = 0;

    serial_borrow_sub #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
        .busy(busy), .done(done), .D(D), .Bout(Bout)
`ifdef SUB_OVERFLOW_EN
       ,.V(V)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one operation from an idle start; noise=1 pulses start during busy and scrambles the inputs
    task automatic op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                      input logic [3:0] ed, input logic eb, input logic noise);
        int n, bc;
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = ~a; B = ~b; Bin = ~bin;
        chk("busy_at_T", busy, 1);
        n = 0; bc = 0;
        while (!done && n < 10) begin
            start = noise && n < 3;
            if (noise) begin A = 4'(n * 5); B = 4'(n + 7); end
            @(posedge clk); #1;
            n++;
            if (busy) bc++;
        end
        start = 1'b0;
        chk("latency", n, 4);
        chk("busy_cycles", bc, 3);
        chk("D", D, ed);
        chk("Bout", Bout, eb);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("D_hold", D, ed);
    endtask

    initial begin
        int n, p1, p2;
        logic [3:0] d1, d2;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_D", D, 0);
        chk("rst_Bout", Bout, 0);
        @(negedge clk); rst_n = 1'b1;

        op(4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 1'b0);
        op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b0);
        op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
        op(4'd5, 4'd5, 1'b0, 4'h0, 1'b0, 1'b0);
        op(4'd15, 4'd0, 1'b1, 4'hE, 1'b0, 1'b0);
        op(4'd0, 4'd15, 1'b0, 4'h1, 1'b1, 1'b0);
        op(4'd8, 4'd8, 1'b1, 4'hF, 1'b1, 1'b0);
        op(4'd12, 4'd10, 1'b1, 4'h1, 1'b0, 1'b1);
`ifdef SUB_OVERFLOW_EN
        op(4'd8, 4'd1, 1'b0, 4'h7, 1'b0, 1'b0);
        chk("V_8m1", V, 1);
        op(4'd7, 4'd8, 1'b0, 4'hF, 1'b1, 1'b0);
        chk("V_7m8", V, 1);
        op(4'd5, 4'd2, 1'b0, 4'h3, 1'b0, 1'b0);
        chk("V_5m2", V, 0);
`endif

        // start held high: accepts again in the DONE cycle
        @(negedge clk);
        A = 4'd9; B = 4'd3; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        p1 = 0; p2 = 0; d1 = '0; d2 = '0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin A = 4'd3; B = 4'd9; end
            if (done && p1 == 0) begin p1 = k; d1 = D; end
            else if (done && p2 == 0) begin p2 = k; d2 = D; end
        end
        start = 1'b0;
        chk("held_done1", p1, 4);
        chk("held_D1", d1, 4'h6);
        chk("held_done2", p2, 9);
        chk("held_D2", d2, 4'hA);
        repeat (8) @(posedge clk);

        // reset mid-operation
        @(negedge clk);
        A = 4'd9; B = 4'd3; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_D", D, 0);
        chk("abort_Bout", Bout, 0);
        chk("abort_done", done, 0);
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        repeat (6) begin @(posedge clk); #1; if (done) n++; end
        chk("abort_no_done", n, 0);
        op(4'd12, 4'd5, 1'b0, 4'h7, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
